// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches one word at a time over
// req/ack and presents it to decode under a valid/ready handshake.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [5:0]  OpCode,
    output logic [5:0]  Funct,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        Jump,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        imem_timeout
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        VALID = 2'd1,
        DROP  = 2'd2
    } state_t;

    localparam logic [15:0] TO = 16'(TIMEOUT);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] saved_pc;
    logic [31:0] pc4;
    logic [31:0] br_off;
    logic [31:0] next_pc;
    logic [15:0] wd_cnt;
    logic [15:0] wd_cnt_nxt;

    assign imem_addr = pc;
    assign OpCode    = inst[31:26];
    assign Funct     = inst[5:0];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush outranks both ack and ready
    always_comb begin
        state_nxt = state;
        case (state)
            FETCH: begin
                if (flush) begin
                    state_nxt = imem_ack ? FETCH : DROP;
                end else if (imem_ack) begin
                    state_nxt = VALID;
                end
            end
            VALID: begin
                if (flush || inst_ready) begin
                    state_nxt = FETCH;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    // Handshake outputs decoded from state; no request while in reset
    always_comb begin
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        case (state)
            FETCH:   imem_req = !rst;
            DROP:    imem_req = !rst;
            VALID:   inst_valid = 1'b1;
            default: imem_req = 1'b0;
        endcase
    end

    // Next PC for the instruction being accepted; jump outranks branch
    always_comb begin
        pc4    = inst_pc + 32'd4;
        br_off = {{14{inst[15]}}, inst[15:0], 2'b00};
        if (Jump) begin
            next_pc = {pc4[31:28], inst[25:0], 2'b00};
        end else if (Branch && Zero) begin
            next_pc = pc4 + br_off;
        end else begin
            next_pc = pc4;
        end
    end

    // PC, captured instruction and pending flush target
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            inst     <= 32'd0;
            inst_pc  <= 32'd0;
            saved_pc <= 32'd0;
        end else begin
            case (state)
                FETCH: begin
                    if (flush && imem_ack) begin
                        pc <= flush_pc;
                    end else if (flush) begin
                        saved_pc <= flush_pc;
                    end else if (imem_ack) begin
                        inst    <= imem_rdata;
                        inst_pc <= pc;
                    end
                end
                VALID: begin
                    if (flush) begin
                        pc <= flush_pc;
                    end else if (inst_ready) begin
                        pc <= next_pc;
                    end
                end
                DROP: begin
                    if (flush && imem_ack) begin
                        pc <= flush_pc;
                    end else if (flush) begin
                        saved_pc <= flush_pc;
                    end else if (imem_ack) begin
                        pc <= saved_pc;
                    end
                end
                default: pc <= pc;
            endcase
        end
    end

    // Watchdog count of unanswered request cycles, saturating
    always_comb begin
        wd_cnt_nxt = wd_cnt;
        if (imem_ack) begin
            wd_cnt_nxt = 16'd0;
        end else if (imem_req && wd_cnt != 16'hFFFF) begin
            wd_cnt_nxt = wd_cnt + 16'd1;
        end
    end

    // Sticky timeout flag; the request itself keeps waiting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt       <= 16'd0;
            imem_timeout <= 1'b0;
        end else begin
            wd_cnt <= wd_cnt_nxt;
            if (TIMEOUT != 0 && wd_cnt_nxt == TO) begin
                imem_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [5:0]  OpCode;
    logic [5:0]  Funct;
    logic        inst_valid;
    logic        inst_ready;
    logic        Jump;
    logic        Branch;
    logic        Zero;
    logic        flush;
    logic [31:0] flush_pc;
    logic        imem_timeout;

    int n_chk = 0;
    int n_err = 0;

    instr_fetch #(
        .RESET_PC(32'h0000_3000),
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .OpCode      (OpCode),
        .Funct       (Funct),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .Jump        (Jump),
        .Branch      (Branch),
        .Zero        (Zero),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .imem_timeout(imem_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        inst_ready = 1'b0;
        Jump       = 1'b0;
        Branch     = 1'b0;
        Zero       = 1'b0;
        flush      = 1'b0;
        flush_pc   = 32'd0;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Zero-wait fetch of one word, then accept it with the given decode flags
    task automatic fetch_accept(input logic [31:0] word, input logic j,
                                input logic b, input logic z,
                                input logic [31:0] exp_pc);
        check("fa_req", 32'(imem_req), 32'd1);
        check("fa_addr", imem_addr, exp_pc);
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack = 1'b0;
        check("fa_valid", 32'(inst_valid), 32'd1);
        check("fa_inst_pc", inst_pc, exp_pc);
        inst_ready = 1'b1;
        Jump       = j;
        Branch     = b;
        Zero       = z;
        tick();
        clear_in();
    endtask

    initial begin
        clear_in();
        rst = 1'b1;
        tick();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_addr", imem_addr, 32'h3000);
        check("rst_tmo", 32'(imem_timeout), 32'd0);
        rst = 1'b0;
        #1;

        // Zero-wait streaming, valid every second cycle
        for (int i = 0; i < 3; i++) begin
            check("zw_req", 32'(imem_req), 32'd1);
            check("zw_addr", imem_addr, 32'h3000 + 32'(4 * i));
            check("zw_novalid", 32'(inst_valid), 32'd0);
            imem_ack   = 1'b1;
            imem_rdata = 32'h0000_0020;
            tick();
            imem_ack = 1'b0;
            check("zw_valid", 32'(inst_valid), 32'd1);
            check("zw_ireq", 32'(imem_req), 32'd0);
            check("zw_inst_pc", inst_pc, 32'h3000 + 32'(4 * i));
            inst_ready = 1'b1;
            tick();
            inst_ready = 1'b0;
        end
        check("zw_addr_end", imem_addr, 32'h300C);

        // Three wait cycles, then the add word
        do_reset();
        for (int i = 0; i < 3; i++) begin
            check("ws_req", 32'(imem_req), 32'd1);
            check("ws_addr", imem_addr, 32'h3000);
            check("ws_novalid", 32'(inst_valid), 32'd0);
            tick();
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'h0085_1020;
        tick();
        imem_ack = 1'b0;
        check("ws_valid", 32'(inst_valid), 32'd1);
        check("ws_opcode", 32'(OpCode), 32'h00);
        check("ws_funct", 32'(Funct), 32'h20);
        check("ws_inst_pc", inst_pc, 32'h3000);

        // Stall decode for five cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            check("st_req", 32'(imem_req), 32'd0);
            check("st_valid", 32'(inst_valid), 32'd1);
            check("st_inst", inst, 32'h0085_1020);
            check("st_funct", 32'(Funct), 32'h20);
            check("st_opcode", 32'(OpCode), 32'h00);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("st_next_req", 32'(imem_req), 32'd1);
        check("st_next_addr", imem_addr, 32'h3004);

        // Branch taken, branch not taken, jump over branch, forward branch
        do_reset();
        fetch_accept(32'h1000_FFFF, 1'b0, 1'b1, 1'b1, 32'h3000);
        check("br_taken", imem_addr, 32'h3000);
        fetch_accept(32'h1000_FFFF, 1'b0, 1'b1, 1'b0, 32'h3000);
        check("br_not", imem_addr, 32'h3004);
        fetch_accept(32'h0800_0C05, 1'b1, 1'b1, 1'b1, 32'h3004);
        check("jump", imem_addr, 32'h3014);
        fetch_accept(32'h1000_0003, 1'b0, 1'b1, 1'b1, 32'h3014);
        check("br_fwd", imem_addr, 32'h3024);

        // Flush during a stalled fetch of 0x3008
        do_reset();
        fetch_accept(32'h0000_0020, 1'b0, 1'b0, 1'b0, 32'h3000);
        fetch_accept(32'h0000_0020, 1'b0, 1'b0, 1'b0, 32'h3004);
        tick();
        tick();
        check("fl_stall_addr", imem_addr, 32'h3008);
        flush    = 1'b1;
        flush_pc = 32'h3100;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("fl_drop_req", 32'(imem_req), 32'd1);
            check("fl_drop_addr", imem_addr, 32'h3008);
            check("fl_drop_valid", 32'(inst_valid), 32'd0);
            tick();
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        check("fl_discard", 32'(inst_valid), 32'd0);
        check("fl_new_req", 32'(imem_req), 32'd1);
        check("fl_new_addr", imem_addr, 32'h3100);

        // Flush while valid, with ready also high
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0020;
        tick();
        imem_ack = 1'b0;
        check("fv_valid", 32'(inst_valid), 32'd1);
        check("fv_inst_pc", inst_pc, 32'h3100);
        flush      = 1'b1;
        flush_pc   = 32'h3100;
        inst_ready = 1'b1;
        tick();
        clear_in();
        check("fv_drop", 32'(inst_valid), 32'd0);
        check("fv_req", 32'(imem_req), 32'd1);
        check("fv_addr", imem_addr, 32'h3100);

        // Flush in the same cycle as the ack
        flush      = 1'b1;
        flush_pc   = 32'h3200;
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0020;
        tick();
        clear_in();
        check("fa_same_valid", 32'(inst_valid), 32'd0);
        check("fa_same_addr", imem_addr, 32'h3200);

        // Watchdog with ack withheld for 20 cycles
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 15) check("wd_15", 32'(imem_timeout), 32'd0);
            if (k == 16) check("wd_16", 32'(imem_timeout), 32'd1);
        end
        check("wd_req_held", 32'(imem_req), 32'd1);
        check("wd_addr_held", imem_addr, 32'h3000);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0020;
        tick();
        imem_ack = 1'b0;
        check("wd_valid", 32'(inst_valid), 32'd1);
        check("wd_sticky", 32'(imem_timeout), 32'd1);

        // Reset in the middle of a wait
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        tick();
        tick();
        check("mr_addr_pre", imem_addr, 32'h3004);
        rst = 1'b1;
        #1;
        check("mr_req", 32'(imem_req), 32'd0);
        check("mr_valid", 32'(inst_valid), 32'd0);
        check("mr_tmo", 32'(imem_timeout), 32'd0);
        check("mr_inst", inst, 32'd0);
        check("mr_inst_pc", inst_pc, 32'd0);
        check("mr_addr", imem_addr, 32'h3000);
        tick();
        rst = 1'b0;
        #1;
        check("mr_restart_req", 32'(imem_req), 32'd1);
        check("mr_restart_addr", imem_addr, 32'h3000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
